bin_to_bcd3: RTL

- Sequential binary-to-decimal converter that sits directly upstream of the 3-digit seven-segment scanner.
- Converts an unsigned binary value into three 4-bit BCD digits (hundreds, tens, units) using iterative shift-and-add-3 (double dabble), one bit per clock.
- Output nibbles drive the scanner's digitL/digitM/digitR inputs directly and are held stable between conversions, so the display never shows partial results.

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bin_to_bcd3_if.sv | 36 +++
 rtl/bcd_digit_adj.sv | 17 +
 rtl/bin_to_bcd3.sv | 128 ++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the bin_to_bcd3 binary-to-BCD converter.
// The optional BIN_TO_BCD3_AUTO_CONVERT_EN feature is selected in bin_to_bcd3.sv.
package bcd_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int BCD_DIGIT_W    = 4;
    localparam int BCD_NUM_DIGITS = 3;
    localparam int BCD_W          = BCD_DIGIT_W * BCD_NUM_DIGITS;

    localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bin_to_bcd3_if.sv
// Request/result bundle between a value source (master) and the bin_to_bcd3 converter (slave).
// Digit nibbles feed the seven-segment scanner directly.
interface bin_to_bcd3_if #(
    parameter int WIDTH = 8
) ();
    import bcd_pkg::*;

    logic                   start;
    logic [WIDTH-1:0]       value;
    logic                   busy;
    logic                   done;
    logic [BCD_DIGIT_W-1:0] digitL;
    logic [BCD_DIGIT_W-1:0] digitM;
    logic [BCD_DIGIT_W-1:0] digitR;

    modport master (
        output start,
        output value,
        input  busy,
        input  done,
        input  digitL,
        input  digitM,
        input  digitR
    );

    modport slave (
        input  start,
        input  value,
        output busy,
        output done,
        output digitL,
        output digitM,
        output digitR
    );

endinterface

// File: rtl/bcd_digit_adj.sv
// Combinational double-dabble correction cell: a nibble of 5 or more gets 3 added
// so that the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    always_comb begin
        dout = din;
        if (din >= BCD_ADJ_THRESH) begin
            dout = din + BCD_ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin_to_bcd3.sv
// Sequential binary to 3-digit BCD converter, one double-dabble iteration per clock.
// Define BIN_TO_BCD3_AUTO_CONVERT_EN to restart conversion automatically whenever value changes.
module bin_to_bcd3
    import bcd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    bin_to_bcd3_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    generate
        if (WIDTH < 4 || WIDTH > 9) begin : g_width_check
            $error("bin_to_bcd3: WIDTH must be in 4..9 so the result fits in three digits");
        end
    endgenerate

    state_t           state_reg,  state_next;
    logic [WIDTH-1:0] bin_reg,    bin_next;
    logic [BCD_W-1:0] bcd_reg,    bcd_next;
    logic [CNT_W-1:0] cnt_reg,    cnt_next;
    logic [BCD_W-1:0] digits_reg, digits_next;
    logic             done_reg,   done_next;
    logic             accept;

    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W+WIDTH-1:0] dabble;
    logic [BCD_W-1:0]       bcd_shift;
    logic [WIDTH-1:0]       bin_shift;

    genvar gi;
    generate
        for (gi = 0; gi < BCD_NUM_DIGITS; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .din  (bcd_reg[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .dout (bcd_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // The accumulator's top bit is always zero for WIDTH <= 9, so dropping it in the shift is safe.
    assign dabble    = {bcd_adj, bin_reg} << 1;
    assign bcd_shift = dabble[BCD_W+WIDTH-1 -: BCD_W];
    assign bin_shift = dabble[WIDTH-1:0];

`ifdef BIN_TO_BCD3_AUTO_CONVERT_EN
    logic [WIDTH-1:0] last_reg, last_next;

    assign accept = bus.start || (bus.value != last_reg);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_reg <= '0;
        end else begin
            last_reg <= last_next;
        end
    end
`else
    assign accept = bus.start;
`endif

    always_comb begin
        state_next  = state_reg;
        bin_next    = bin_reg;
        bcd_next    = bcd_reg;
        cnt_next    = cnt_reg;
        digits_next = digits_reg;
        done_next   = 1'b0;
`ifdef BIN_TO_BCD3_AUTO_CONVERT_EN
        last_next   = last_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = SHIFT;
                    bin_next   = bus.value;
                    bcd_next   = '0;
                    cnt_next   = CNT_W'(WIDTH);
`ifdef BIN_TO_BCD3_AUTO_CONVERT_EN
                    last_next  = bus.value;
`endif
                end
            end
            SHIFT: begin
                bin_next = bin_shift;
                bcd_next = bcd_shift;
                cnt_next = cnt_reg - CNT_W'(1);
                // Publish all three digits together so the display never sees a partial result.
                if (cnt_reg == CNT_W'(1)) begin
                    digits_next = bcd_shift;
                    done_next   = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            bin_reg    <= '0;
            bcd_reg    <= '0;
            cnt_reg    <= '0;
            digits_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            bin_reg    <= bin_next;
            bcd_reg    <= bcd_next;
            cnt_reg    <= cnt_next;
            digits_reg <= digits_next;
            done_reg   <= done_next;
        end
    end

    assign bus.busy   = (state_reg == SHIFT);
    assign bus.done   = done_reg;
    assign bus.digitL = digits_reg[2*BCD_DIGIT_W +: BCD_DIGIT_W];
    assign bus.digitM = digits_reg[1*BCD_DIGIT_W +: BCD_DIGIT_W];
    assign bus.digitR = digits_reg[0*BCD_DIGIT_W +: BCD_DIGIT_W];

endmodule
